// File: rtl/fifo_8x32.sv
// 8-entry x 32-bit synchronous FIFO with registered read data,
// occupancy count, full/empty flags and per-cycle ack/err status.
module fifo_8x32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [31:0] din,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic [3:0]  data_count,
    output logic        full,
    output logic        empty,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        rd_ack,
    output logic        rd_err
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WR_RD,
        WR_ERR,
        RD_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_mem [8];
    logic [2:0]  r_wr_ptr;
    logic [2:0]  r_rd_ptr;
    logic [3:0]  r_count;
    logic [31:0] r_dout;
    logic        w_full;
    logic        w_empty;
    logic        w_do_wr;
    logic        w_do_rd;

    assign w_full  = (r_count == 4'd8);
    assign w_empty = (r_count == 4'd0);

    // Both requests degrade to a single operation at the empty/full edges
    always_comb begin
        w_state_nxt = IDLE;
        case ({wr_en, rd_en})
            2'b10:   w_state_nxt = w_full  ? WR_ERR : WRITE;
            2'b01:   w_state_nxt = w_empty ? RD_ERR : READ;
            2'b11: begin
                if (w_empty)
                    w_state_nxt = WRITE;
                else if (w_full)
                    w_state_nxt = READ;
                else
                    w_state_nxt = WR_RD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_do_wr = (w_state_nxt == WRITE) || (w_state_nxt == WR_RD);
    assign w_do_rd = (w_state_nxt == READ)  || (w_state_nxt == WR_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 4'd0;
            r_dout   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            if (w_do_wr && !w_do_rd)
                r_count <= r_count + 4'd1;
            else if (w_do_rd && !w_do_wr)
                r_count <= r_count - 4'd1;
        end
    end

    // Storage needs no reset; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= din;
    end

    assign dout       = r_dout;
    assign data_count = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign wr_ack     = (r_state == WRITE) || (r_state == WR_RD);
    assign rd_ack     = (r_state == READ)  || (r_state == WR_RD);
    assign wr_err     = (r_state == WR_ERR);
    assign rd_err     = (r_state == RD_ERR);

endmodule

// File: tb/tb_fifo_8x32.sv
// Directed table-driven bench for fifo_8x32 plus hand-written
// sequences for asynchronous reset and pointer wrap-around.
module tb_fifo_8x32;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_en;
    logic [31:0] dout;
    logic [3:0]  data_count;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic [3:0]  cnt;
        logic [3:0]  st;
    } vec_t;

    vec_t tbl[$];

    fifo_8x32 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h",
                     nm, idx, act, exp);
        end
    endtask

    // st = {wr_ack, wr_err, rd_ack, rd_err}
    task automatic chk_all(input string nm, input int idx,
                           input logic [31:0] e_dout,
                           input logic [3:0] e_cnt,
                           input logic [3:0] e_st);
        chk({nm, ".dout"}, idx, dout, e_dout);
        chk({nm, ".count"}, idx, 32'(data_count), 32'(e_cnt));
        chk({nm, ".full"}, idx, 32'(full), 32'(e_cnt == 4'd8));
        chk({nm, ".empty"}, idx, 32'(empty), 32'(e_cnt == 4'd0));
        chk({nm, ".status"}, idx,
            32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(e_st));
    endtask

    task automatic add(input logic w, input logic r, input logic [31:0] d,
                       input logic [31:0] e_dout, input logic [3:0] e_cnt,
                       input logic [3:0] e_st);
        vec_t v;
        v.wr   = w;
        v.rd   = r;
        v.din  = d;
        v.dout = e_dout;
        v.cnt  = e_cnt;
        v.st   = e_st;
        tbl.push_back(v);
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 32'd0;
        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 32'd0;

        for (int i = 1; i <= 8; i++)
            add(1, 0, 32'(i), 32'd0, 4'(i), 4'b1000);
        add(1, 0, 32'hDEADBEEF, 32'd0, 4'd8, 4'b0100);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 32'd0, 32'(k), 4'(8 - k), 4'b0010);
        add(0, 1, 32'd0, 32'd8, 4'd0, 4'b0001);
        add(1, 1, 32'hA5A5A5A5, 32'd8, 4'd1, 4'b1000);
        add(0, 1, 32'd0, 32'hA5A5A5A5, 4'd0, 4'b0010);
        for (int j = 1; j <= 3; j++)
            add(1, 0, 32'h20 + 32'(j), 32'hA5A5A5A5, 4'(j), 4'b1000);
        add(1, 1, 32'hA5A5A5A5, 32'h21, 4'd3, 4'b1010);
        for (int j = 4; j <= 8; j++)
            add(1, 0, 32'h20 + 32'(j), 32'h21, 4'(j), 4'b1000);
        add(1, 1, 32'hA5A5A5A5, 32'h22, 4'd7, 4'b0010);
        for (int j = 0; j < 4; j++)
            add(0, 0, 32'd0, 32'h22, 4'd7, 4'b0000);
        add(0, 1, 32'd0, 32'h23, 4'd6, 4'b0010);

        #7;
        chk_all("reset", 0, 32'd0, 4'd0, 4'b0000);
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk_all("vec", i, tbl[i].dout, tbl[i].cnt, tbl[i].st);
        end

        // Asynchronous reset mid-stream, checked before any clock edge
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 0, 32'hC0 + 32'(i));
        step(0, 1, 32'd0);
        chk_all("pre_rst", 0, 32'hC0, 4'd2, 4'b0010);
        @(negedge clk);
        rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'd0, 4'd0, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 32'd0);
        chk_all("rst_rd", 0, 32'd0, 4'd0, 4'b0001);

        // Pointer wrap-around past entry 7
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, 0, 32'h1 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'd0);
            chk("wrap_pre.dout", i, dout, 32'h1 + 32'(i));
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 32'h10 + 32'(i));
            chk("wrap_wr.count", i, 32'(data_count), 32'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'd0);
            chk_all("wrap_rd", i, 32'h10 + 32'(i), 4'(5 - i), 4'b0010);
        end

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
